fir_mac_filter: RTL and testbench

- Parametrised successor to the fixed 3-tap summing filter: a TAPS-deep FIR with run-time programmable signed coefficients.
- One shared multiplier evaluates the taps sequentially, one multiply-accumulate per clock.
- Sits between the ADC sample interface and downstream DSP; adds valid/ready handshaking and rounding/scaling.
- Reset coefficients reproduce the legacy x[n]+x[n-1]+x[n-2] response.

---
 rtl/fir_mac_filter.sv | 142 ++++++++++++++
 tb/tb_fir_mac_filter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_filter.sv
// TAPS-deep FIR with programmable coefficients and one shared multiplier (one MAC per clock).
// Define FIR_SAT_EN to clamp out-of-range results to the output range and flag them on sat.
module fir_mac_filter #(
    parameter int unsigned TAPS   = 6,
    parameter int unsigned DIN_W  = 12,
    parameter int unsigned COEF_W = 12,
    parameter int unsigned DOUT_W = 12,
    parameter int unsigned SHIFT  = 0,
    localparam int unsigned ACC_W  = DIN_W + COEF_W + $clog2(TAPS),
    localparam int unsigned ADDR_W = ($clog2(TAPS) > 1) ? $clog2(TAPS) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              filterdav,
    input  logic [DIN_W-1:0]  data_in,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic              coef_we,
    input  logic [ADDR_W-1:0] coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    output logic [DOUT_W-1:0] data_out,
    output logic              dout_valid,
    output logic              sat
);

    typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

    // Half an output LSB, added before the shift so the result rounds half up.
    localparam logic signed [ACC_W:0] RND = (ACC_W + 1)'((2 ** SHIFT) / 2);

    state_e                    state_q, state_d;
    logic signed [DIN_W-1:0]   x_q    [TAPS];
    logic signed [COEF_W-1:0]  coef_q [TAPS];
    logic signed [ACC_W-1:0]   acc_q;
    logic [ADDR_W-1:0]         idx_q;
    logic [DOUT_W-1:0]         data_out_q;
    logic                      dout_valid_q;
    logic                      sat_q;

    logic                      accept;
    logic                      last_tap;
    logic signed [DIN_W+COEF_W-1:0] prod;
    logic signed [ACC_W:0]     rnd_sum;
    logic signed [ACC_W:0]     r;
    logic [DOUT_W-1:0]         r_out;
    logic                      r_sat;

    assign din_ready  = (state_q == StIdle) && !filterdav;
    assign accept     = din_valid && din_ready;
    assign last_tap   = (idx_q == ADDR_W'(TAPS - 1));
    assign prod       = x_q[idx_q] * coef_q[idx_q];
    assign rnd_sum    = (ACC_W + 1)'(acc_q) + RND;
    assign r          = rnd_sum >>> SHIFT;
    assign data_out   = data_out_q;
    assign dout_valid = dout_valid_q;
    assign sat        = sat_q;

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W:0] OUT_MAX = (ACC_W + 1)'((2 ** (DOUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] OUT_MIN = ~OUT_MAX;

    always_comb begin
        r_out = r[DOUT_W-1:0];
        r_sat = 1'b0;
        if (r > OUT_MAX) begin
            r_out = OUT_MAX[DOUT_W-1:0];
            r_sat = 1'b1;
        end else if (r < OUT_MIN) begin
            r_out = OUT_MIN[DOUT_W-1:0];
            r_sat = 1'b1;
        end
    end
`else
    logic unused_r_msbs;
    assign unused_r_msbs = ^r[ACC_W:DOUT_W];
    assign r_out         = r[DOUT_W-1:0];
    assign r_sat         = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (filterdav) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: if (accept) state_d = StMac;
                StMac:  if (last_tap) state_d = StOut;
                StOut:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            acc_q        <= '0;
            idx_q        <= '0;
            data_out_q   <= '0;
            dout_valid_q <= 1'b0;
            sat_q        <= 1'b0;
            for (int k = 0; k < int'(TAPS); k++) begin
                x_q[k]    <= '0;
                coef_q[k] <= (k < 3) ? COEF_W'(1) : '0;
            end
        end else begin
            state_q      <= state_d;
            dout_valid_q <= 1'b0;
            if (filterdav) begin
                acc_q <= '0;
                idx_q <= '0;
                for (int k = 0; k < int'(TAPS); k++) x_q[k] <= '0;
            end else begin
                // Writes only land while idle, so an in-flight result never sees them.
                if (state_q == StIdle && coef_we && 32'(coef_addr) < TAPS) begin
                    coef_q[coef_addr] <= coef_data;
                end
                unique case (state_q)
                    StIdle: begin
                        if (accept) begin
                            x_q[0] <= data_in;
                            for (int k = int'(TAPS) - 1; k > 0; k--) x_q[k] <= x_q[k-1];
                            acc_q <= '0;
                            idx_q <= '0;
                        end
                    end
                    StMac: begin
                        acc_q <= acc_q + ACC_W'(prod);
                        idx_q <= idx_q + 1'b1;
                    end
                    StOut: begin
                        data_out_q   <= r_out;
                        sat_q        <= r_sat;
                        dout_valid_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fir_mac_filter.sv
// Directed bench for fir_mac_filter: a default instance and a SHIFT=2 instance for rounding.
module tb_fir_mac_filter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        filterdav, din_valid, coef_we;
    logic [11:0] data_in, coef_data, data_out;
    logic [2:0]  coef_addr;
    logic        din_ready, dout_valid, sat;

    logic        din_valid_r;
    logic [11:0] data_in_r, data_out_r;
    logic        din_ready_r, dout_valid_r, sat_r;
    logic        zero_bit = 1'b0;
    logic [2:0]  zero_addr = 3'd0;
    logic [11:0] zero_coef = 12'd0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    fir_mac_filter dut (
        .clock(clock), .reset_n(reset_n), .filterdav(filterdav),
        .data_in(data_in), .din_valid(din_valid), .din_ready(din_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .data_out(data_out), .dout_valid(dout_valid), .sat(sat)
    );

    fir_mac_filter #(.SHIFT(2)) dut_rnd (
        .clock(clock), .reset_n(reset_n), .filterdav(zero_bit),
        .data_in(data_in_r), .din_valid(din_valid_r), .din_ready(din_ready_r),
        .coef_we(zero_bit), .coef_addr(zero_addr), .coef_data(zero_coef),
        .data_out(data_out_r), .dout_valid(dout_valid_r), .sat(sat_r)
    );

    task automatic check(input int obs, input int exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Offer one sample, wait for its result, check the latency and optionally the value.
    task automatic feed(input bit use_r, input int s, input bit chk, input int expv,
                        input bit exp_sat, input string tag);
        int lat;
        @(negedge clock);
        if (use_r) begin din_valid_r = 1'b1; data_in_r = 12'(s); end
        else begin din_valid = 1'b1; data_in = 12'(s); end
        check(int'(use_r ? din_ready_r : din_ready), 1, {tag, "_ready"});
        @(posedge clock);
        #1;
        din_valid   = 1'b0;
        din_valid_r = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(posedge clock);
            #1;
            if (use_r ? dout_valid_r : dout_valid) lat = i;
        end
        check(lat, 7, {tag, "_latency"});
        if (chk) begin
            check(int'(use_r ? data_out_r : data_out), expv, {tag, "_data"});
            check(int'(use_r ? sat_r : sat), int'(exp_sat), {tag, "_sat"});
        end
    endtask

    task automatic write_coef(input int addr, input int val);
        @(negedge clock);
        coef_we = 1'b1; coef_addr = 3'(addr); coef_data = 12'(val);
        @(negedge clock);
        coef_we = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clock);
        filterdav = 1'b1;
        @(negedge clock);
        filterdav = 1'b0;
    endtask

    initial begin
        int exp_hs [4] = '{100, 201, 303, 306};
        int seen;
        reset_n = 1'b0; filterdav = 1'b0; din_valid = 1'b0; coef_we = 1'b0;
        data_in = '0; coef_addr = '0; coef_data = '0;
        din_valid_r = 1'b0; data_in_r = '0;
        #23;
        check(int'(data_out), 0, "rst_data_out");
        check(int'(dout_valid), 0, "rst_dout_valid");
        check(int'(sat), 0, "rst_sat");
        check(int'(din_ready), 1, "rst_din_ready");
        reset_n = 1'b1;

        // Default coefficients reproduce x[n]+x[n-1]+x[n-2].
        feed(0, 10, 1, 10, 0, "def0");
        feed(0, 20, 1, 30, 0, "def1");
        feed(0, 30, 1, 60, 0, "def2");
        feed(0, 40, 1, 90, 0, "def3");

        // Async reset in the middle of MAC.
        @(negedge clock);
        din_valid = 1'b1; data_in = 12'd55;
        @(posedge clock); #1; din_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        check(int'(data_out), 0, "midrst_data_out");
        check(int'(dout_valid), 0, "midrst_dout_valid");
        check(int'(din_ready), 1, "midrst_din_ready");
        @(negedge clock);
        reset_n = 1'b1;

        // din_valid held high with ramp data: one accept every 8 cycles.
        @(negedge clock);
        din_valid = 1'b1;
        for (int n = 0; n < 4; n++) begin
            data_in = 12'(100 + n);
            check(int'(din_ready), 1, "hs_ready_hi");
            if (n > 0) begin
                check(int'(dout_valid), 1, "hs_valid");
                check(int'(data_out), exp_hs[n-1], "hs_data");
            end
            seen = 0;
            for (int c = 0; c < 7; c++) begin
                @(negedge clock);
                if (din_ready || dout_valid) seen++;
            end
            check(seen, 0, "hs_busy_window");
            @(negedge clock);
        end
        din_valid = 1'b0;
        check(int'(dout_valid), 1, "hs_valid_last");
        check(int'(data_out), exp_hs[3], "hs_data_last");

        // Impulse response with coef[k] = k+1.
        for (int k = 0; k < 6; k++) write_coef(k, k + 1);
        pulse_clear();
        feed(0, 1, 1, 1, 0, "imp0");
        for (int k = 1; k < 7; k++) feed(0, 0, 1, (k < 6) ? k + 1 : 0, 0, "imp");

        // Coefficient write while busy is ignored.
        pulse_clear();
        @(negedge clock);
        din_valid = 1'b1; data_in = 12'd7;
        @(negedge clock);
        din_valid = 1'b0; coef_we = 1'b1; coef_addr = 3'd0; coef_data = 12'd100;
        @(negedge clock);
        coef_we = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clock);
            if (dout_valid) seen = 1;
        end
        check(seen, 1, "busy_wr_valid");
        check(int'(data_out), 7, "busy_wr_data");

        // filterdav mid-MAC discards the in-flight result.
        @(negedge clock);
        din_valid = 1'b1; data_in = 12'd9;
        @(negedge clock);
        din_valid = 1'b0;
        repeat (2) @(negedge clock);
        filterdav = 1'b1;
        @(negedge clock);
        filterdav = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            if (dout_valid) seen++;
        end
        check(seen, 0, "clr_no_valid");
        check(int'(data_out), 7, "clr_data_held");
        feed(0, 5, 1, 5, 0, "after_clr");

        // Overflow: all coefficients 2047, six samples of 2047.
        for (int k = 0; k < 6; k++) write_coef(k, 2047);
        pulse_clear();
        for (int k = 0; k < 5; k++) feed(0, 2047, 0, 0, 0, "ovf_fill");
`ifdef FIR_SAT_EN
        feed(0, 2047, 1, 2047, 1, "ovf");
`else
        feed(0, 2047, 1, 6, 0, "ovf");
`endif

        // SHIFT=2 rounding: 1/4 -> 0, 2/4 -> 1.
        feed(1, 1, 1, 0, 0, "rnd0");
        feed(1, 1, 1, 1, 0, "rnd1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
